ae_cfg_seq: RTL and testbench
=============================

Name: ae_cfg_seq

Overview:
- Sequences manual AE updates into camera sensor register writes.
- Consumes the (request pulse, 8-bit AE level) pair produced by the button-driven AE setter and converts the level into exposure and gain values.
- Issues a group-held burst of single-register writes to the shared IIC write master, with retry and timeout, then reports completion back to the AE setter.
- Sits between the AE setter and the IIC master. It is gated until initial camera configuration completes.

Parameters:
- HOLD_ADDR, 16'h3001, sensor group-hold register address.
- EXPH_ADDR, 16'h3021, exposure high-byte register address.
- EXPL_ADDR, 16'h3020, exposure low-byte register address.
- GAIN_ADDR, 16'h3014, analog gain register address.
- EXP_STEP, 8'd40, exposure lines per AE step.
- GAIN_THRESH, 8'd100, AE level above which gain is raised instead of exposure.
- GAIN_STEP, 4'd2, gain codes per AE step above GAIN_THRESH.
- TIMEOUT_CYC, 24'd2_400_000, cycles to wait for IIC done (100 ms at 24 MHz).
- MAX_RETRY, 2'd2, re-attempts of a failed write before aborting.

Ports:
- I_clk, in, 1, system clock (24 MHz).
- I_rst, in, 1, synchronous active-high reset.
- I_cam_cfg_done, in, 1, level; high once initial sensor config is finished.
- I_ae_req, in, 1, one-cycle AE update request.
- I_ae, in, 8, AE level; sampled when I_ae_req=1.
- O_iic_req, out, 1, write request to IIC master; held until I_iic_done.
- O_iic_addr, out, 16, register address; stable while O_iic_req=1.
- O_iic_data, out, 8, register data; stable while O_iic_req=1.
- I_iic_done, in, 1, one-cycle pulse: current write finished.
- I_iic_err, in, 1, valid with I_iic_done; NACK on the write.
- O_ae_cfg_done, out, 1, one-cycle pulse when a burst completes successfully.
- O_busy, out, 1, high from burst start until DONE/ABORT exits.
- O_err, out, 1, sticky abort flag; cleared on next accepted burst start.

Behaviour:
- Reset (I_rst=1 at clock edge) drives all outputs to 0, puts the FSM in IDLE, and clears pending, retry and timeout state.
- Reset mid-burst abandons the burst; no further writes are issued. The IIC master is reset by the same signal.
- Request capture:
  - I_ae_req=1 in any state loads pend_ae<=I_ae and sets pend_vld<=1. Latest value wins; earlier pending values are overwritten.
  - Requests that arrive while I_cam_cfg_done=0 are still captured.
- FSM states: IDLE, CALC, ISSUE, WAIT, NEXT, DONE, ABORT.
- IDLE → CALC when pend_vld && I_cam_cfg_done. CALC copies pend_ae into the working register and clears pend_vld. If I_ae_req=1 in that same cycle, the new request wins and pend_vld stays 1.
- CALC (1 cycle) computes the burst values:
  - exp = min(ae,GAIN_THRESH)*EXP_STEP, 16-bit, saturating at 16'hFFFF.
  - gain = (ae>GAIN_THRESH) ? (ae-GAIN_THRESH)*GAIN_STEP : 0, 8-bit, saturating at 8'hFF.
  - Sets O_busy=1, O_err<=0, widx=0.
- Burst order (widx 0..4):
  - 0: HOLD_ADDR ← 8'h01
  - 1: EXPH_ADDR ← exp[15:8]
  - 2: EXPL_ADDR ← exp[7:0]
  - 3: GAIN_ADDR ← gain
  - 4: HOLD_ADDR ← 8'h00
- ISSUE: assert O_iic_req with addr/data for widx, clear the timeout counter, then go to WAIT. First O_iic_req occurs exactly 2 cycles after the IDLE→CALC transition edge.
- WAIT: O_iic_req stays high and the timeout counter increments each cycle.
  - I_iic_done && !I_iic_err: drop O_iic_req, clear retry count, go to NEXT.
  - I_iic_done && I_iic_err, or counter reaches TIMEOUT_CYC-1: drop O_iic_req. If retry<MAX_RETRY, increment retry and return to ISSUE (same widx). Otherwise go to ABORT.
  - O_iic_req is low for at least 1 cycle between consecutive writes.
- NEXT: if widx==4 go to DONE; otherwise widx++ and go to ISSUE.
- DONE: O_ae_cfg_done=1 for 1 cycle, O_busy<=0, go to IDLE. A pending request restarts via IDLE on the next cycle.
- ABORT:
  - If widx is 1..3: issue one best-effort HOLD_ADDR←8'h00 write (no retry; result ignored; timeout still applies) so the sensor is not left in group hold.
  - Then set O_err=1, O_busy<=0, go to IDLE. No O_ae_cfg_done pulse.
  - If widx is 0 or 4, skip the release write.
- I_cam_cfg_done falling mid-burst is ignored; the current burst completes. A new burst only starts while it is high.
- I_iic_done outside WAIT is ignored.

Test Plan:
- I_cam_cfg_done=1, req with I_ae=50, IIC done 3 cycles after each req, no error → 5 writes: (3001,01), (3021,07), (3020,D0), (3014,00), (3001,00); O_ae_cfg_done pulses once; O_busy low afterwards.
- I_ae=120 → exp=100*40=0x0FA0, gain=20*2=0x28 → writes (3021,0F), (3020,A0), (3014,28).
- Requests with I_ae=60 then 61 then 62 during a running burst → exactly one further burst, carrying 62's values (exp=0x09B0).
- I_iic_err on write idx 2 three consecutive times → write 2 issued 3 times, then release (3001,00), O_err=1, no O_ae_cfg_done; next req clears O_err.
- Req while I_cam_cfg_done=0 → no O_iic_req; raising I_cam_cfg_done starts the burst 2 cycles later.
- I_rst pulsed while in WAIT at widx 3 → O_iic_req=0 next cycle, all outputs 0, no further writes until a new req.

Source files
------------

// File: rtl/ae_cfg_seq.sv
// ---------------------------------------------------------------------------
// ae_cfg_seq
//   Turns a manual AE level from the button-driven AE setter into a
//   group-held burst of sensor register writes via the shared IIC write
//   master. Each write is retried on NACK or timeout. Completion (or abort)
//   is reported back to the AE setter. No burst starts until the initial
//   camera configuration has finished.
//
// Ports
//   I_clk          system clock (24 MHz)
//   I_rst          synchronous active-high reset
//   I_cam_cfg_done level, initial sensor configuration finished
//   I_ae_req       one-cycle AE update request
//   I_ae[7:0]      AE level, sampled with I_ae_req
//   O_iic_req      write request to IIC master, held until I_iic_done
//   O_iic_addr     register address, stable while O_iic_req
//   O_iic_data     register data, stable while O_iic_req
//   I_iic_done     one-cycle pulse, current write finished
//   I_iic_err      NACK, valid with I_iic_done
//   O_ae_cfg_done  one-cycle pulse on successful burst completion
//   O_busy         high from burst start until the burst exits
//   O_err          sticky abort flag, cleared when the next burst starts
// ---------------------------------------------------------------------------
module ae_cfg_seq #(
    parameter logic [15:0] HOLD_ADDR   = 16'h3001,
    parameter logic [15:0] EXPH_ADDR   = 16'h3021,
    parameter logic [15:0] EXPL_ADDR   = 16'h3020,
    parameter logic [15:0] GAIN_ADDR   = 16'h3014,
    parameter logic [7:0]  EXP_STEP    = 8'd40,
    parameter logic [7:0]  GAIN_THRESH = 8'd100,
    parameter logic [3:0]  GAIN_STEP   = 4'd2,
    parameter logic [23:0] TIMEOUT_CYC = 24'd2_400_000,
    parameter logic [1:0]  MAX_RETRY   = 2'd2
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_cam_cfg_done,
    input  logic        I_ae_req,
    input  logic [7:0]  I_ae,
    output logic        O_iic_req,
    output logic [15:0] O_iic_addr,
    output logic [7:0]  O_iic_data,
    input  logic        I_iic_done,
    input  logic        I_iic_err,
    output logic        O_ae_cfg_done,
    output logic        O_busy,
    output logic        O_err
);

    // REL_WAIT waits on the best-effort group-hold release issued from ABORT.
    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_NEXT, S_DONE, S_ABORT, S_REL_WAIT
    } state_t;

    state_t      state_q, state_d;

    logic [7:0]  pend_ae_q;
    logic        pend_vld_q;
    logic [15:0] exp_q;
    logic [7:0]  gain_q;
    logic [2:0]  widx_q;
    logic [1:0]  retry_q;
    logic [23:0] tmo_q;

    logic        req_q, req_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    // ---------------- exposure / gain arithmetic ----------------
    logic [7:0]  ae_lim;
    logic [16:0] exp_prod;
    logic [15:0] exp_sat;
    logic [7:0]  gain_diff;
    logic [11:0] gain_prod;
    logic [7:0]  gain_sat;

    always_comb begin
        ae_lim    = (pend_ae_q > GAIN_THRESH) ? GAIN_THRESH : pend_ae_q;
        exp_prod  = 17'(ae_lim) * 17'(EXP_STEP);
        exp_sat   = exp_prod[16] ? 16'hFFFF : exp_prod[15:0];
        gain_diff = (pend_ae_q > GAIN_THRESH) ? (pend_ae_q - GAIN_THRESH) : 8'd0;
        gain_prod = 12'(gain_diff) * 12'(GAIN_STEP);
        gain_sat  = (|gain_prod[11:8]) ? 8'hFF : gain_prod[7:0];
    end

    // ---------------- handshake events ----------------
    logic tmo_hit, wait_ok, wait_fail, rel_end, rel_needed, retry_left;

    always_comb begin
        tmo_hit    = (tmo_q == TIMEOUT_CYC - 24'd1);
        // A done pulse in the timeout cycle takes priority over the timeout.
        wait_ok    = (state_q == S_WAIT) && I_iic_done && !I_iic_err;
        wait_fail  = (state_q == S_WAIT) &&
                     ((I_iic_done && I_iic_err) || (!I_iic_done && tmo_hit));
        rel_end    = (state_q == S_REL_WAIT) && (I_iic_done || tmo_hit);
        // Only bursts aborted after the hold was set and before it was
        // released need the release write.
        rel_needed = (widx_q >= 3'd1) && (widx_q <= 3'd3);
        retry_left = (retry_q < MAX_RETRY);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (pend_vld_q && I_cam_cfg_done) state_d = S_CALC;
            S_CALC:     state_d = S_ISSUE;
            S_ISSUE:    state_d = S_WAIT;
            S_WAIT: begin
                if (wait_ok)        state_d = S_NEXT;
                else if (wait_fail) state_d = retry_left ? S_ISSUE : S_ABORT;
            end
            S_NEXT:     state_d = (widx_q == 3'd4) ? S_DONE : S_ISSUE;
            S_DONE:     state_d = S_IDLE;
            S_ABORT:    state_d = rel_needed ? S_REL_WAIT : S_IDLE;
            S_REL_WAIT: if (rel_end) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (next value of output registers) -------
    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        data_d = data_q;
        busy_d = busy_q;
        err_d  = err_q;
        case (state_q)
            S_CALC: begin
                busy_d = 1'b1;
                err_d  = 1'b0;
            end
            S_ISSUE: begin
                req_d = 1'b1;
                case (widx_q)
                    3'd0:    begin addr_d = HOLD_ADDR; data_d = 8'h01;        end
                    3'd1:    begin addr_d = EXPH_ADDR; data_d = exp_q[15:8];  end
                    3'd2:    begin addr_d = EXPL_ADDR; data_d = exp_q[7:0];   end
                    3'd3:    begin addr_d = GAIN_ADDR; data_d = gain_q;       end
                    default: begin addr_d = HOLD_ADDR; data_d = 8'h00;        end
                endcase
            end
            S_WAIT: begin
                if (wait_ok || wait_fail) req_d = 1'b0;
            end
            S_DONE: begin
                busy_d = 1'b0;
            end
            S_ABORT: begin
                if (rel_needed) begin
                    req_d  = 1'b1;
                    addr_d = HOLD_ADDR;
                    data_d = 8'h00;
                end else begin
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                end
            end
            S_REL_WAIT: begin
                if (rel_end) begin
                    req_d  = 1'b0;
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath and output registers ----------------
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            pend_ae_q  <= 8'd0;
            pend_vld_q <= 1'b0;
            exp_q      <= 16'd0;
            gain_q     <= 8'd0;
            widx_q     <= 3'd0;
            retry_q    <= 2'd0;
            tmo_q      <= 24'd0;
            req_q      <= 1'b0;
            addr_q     <= 16'd0;
            data_q     <= 8'd0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // A request in the CALC cycle itself stays pending.
            if (I_ae_req) begin
                pend_ae_q  <= I_ae;
                pend_vld_q <= 1'b1;
            end else if (state_q == S_CALC) begin
                pend_vld_q <= 1'b0;
            end

            case (state_q)
                S_CALC: begin
                    exp_q   <= exp_sat;
                    gain_q  <= gain_sat;
                    widx_q  <= 3'd0;
                    retry_q <= 2'd0;
                end
                S_ISSUE: tmo_q <= 24'd0;
                S_WAIT: begin
                    tmo_q <= tmo_q + 24'd1;
                    if (wait_ok)
                        retry_q <= 2'd0;
                    else if (wait_fail && retry_left)
                        retry_q <= retry_q + 2'd1;
                end
                S_NEXT: if (widx_q != 3'd4) widx_q <= widx_q + 3'd1;
                S_ABORT: tmo_q <= 24'd0;
                S_REL_WAIT: tmo_q <= tmo_q + 24'd1;
                default: ;
            endcase

            req_q  <= req_d;
            addr_q <= addr_d;
            data_q <= data_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign O_iic_req     = req_q;
    assign O_iic_addr    = addr_q;
    assign O_iic_data    = data_q;
    assign O_busy        = busy_q;
    assign O_err         = err_q;
    assign O_ae_cfg_done = (state_q == S_DONE);

endmodule

// File: tb/tb_ae_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_ae_cfg_seq
//   Scoreboard bench for ae_cfg_seq. Stimulus pushes the hand-computed
//   register writes of each expected burst into a queue; a monitor pops one
//   entry per rising O_iic_req and compares. An IIC responder answers each
//   write three cycles after it appears, optionally with NACKs or not at all.
//   The timeout is shortened so timeout behaviour fits in a short run.
// ---------------------------------------------------------------------------
module tb_ae_cfg_seq;

    logic        clk;
    logic        rst;
    logic        cam_cfg_done;
    logic        ae_req;
    logic [7:0]  ae;
    logic        iic_req;
    logic [15:0] iic_addr;
    logic [7:0]  iic_data;
    logic        iic_done;
    logic        iic_err;
    logic        ae_cfg_done;
    logic        busy;
    logic        err;

    ae_cfg_seq #(.TIMEOUT_CYC(24'd8)) dut (
        .I_clk          (clk),
        .I_rst          (rst),
        .I_cam_cfg_done (cam_cfg_done),
        .I_ae_req       (ae_req),
        .I_ae           (ae),
        .O_iic_req      (iic_req),
        .O_iic_addr     (iic_addr),
        .O_iic_data     (iic_data),
        .I_iic_done     (iic_done),
        .I_iic_err      (iic_err),
        .O_ae_cfg_done  (ae_cfg_done),
        .O_busy         (busy),
        .O_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    logic [23:0] exp_wr[$];

    logic        no_resp = 1'b0;
    logic [15:0] err_addr = 16'h0000;
    int          err_left = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic mon_prev = 1'b0;
    always @(negedge clk) begin
        if (iic_req && !mon_prev) begin
            wr_cnt++;
            n_cmp++;
            if (exp_wr.size() == 0) begin
                n_bad++;
                $display("FAIL write: unexpected write addr=%h data=%h", iic_addr, iic_data);
            end else begin
                logic [23:0] e;
                e = exp_wr.pop_front();
                if ({iic_addr, iic_data} !== e) begin
                    n_bad++;
                    $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                             iic_addr, iic_data, e[23:8], e[7:0]);
                end else begin
                    $display("ok   write: addr=%h data=%h", iic_addr, iic_data);
                end
            end
        end
        mon_prev = iic_req;
        if (ae_cfg_done) done_cnt++;
    end

    // ---------------- IIC responder ----------------
    initial begin
        logic [15:0] a;
        iic_done = 1'b0;
        iic_err  = 1'b0;
        forever begin
            @(negedge clk);
            if (iic_req && !no_resp) begin
                a = iic_addr;
                repeat (2) @(negedge clk);
                iic_done = 1'b1;
                iic_err  = (a == err_addr) && (err_left > 0);
                if (iic_err) err_left--;
                @(negedge clk);
                iic_done = 1'b0;
                iic_err  = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_burst(input logic [15:0] e, input logic [7:0] g);
        exp_wr.push_back({16'h3001, 8'h01});
        exp_wr.push_back({16'h3021, e[15:8]});
        exp_wr.push_back({16'h3020, e[7:0]});
        exp_wr.push_back({16'h3014, g});
        exp_wr.push_back({16'h3001, 8'h00});
    endtask

    task automatic send_req(input logic [7:0] v);
        ae     = v;
        ae_req = 1'b1;
        @(negedge clk);
        ae_req = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string nm);
        int k;
        k = 0;
        while (busy !== lvl && k < max) begin
            @(negedge clk);
            k++;
        end
        if (busy !== lvl) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy stayed %b, required %b within %0d cycles", nm, busy, lvl, max);
        end
    endtask

    // Directed table: AE level and its hand-computed exposure / gain.
    logic [7:0]  tab_ae[5]   = '{8'd50,   8'd120,  8'd100,  8'd227,  8'd255};
    logic [15:0] tab_exp[5]  = '{16'h07D0, 16'h0FA0, 16'h0FA0, 16'h0FA0, 16'h0FA0};
    logic [7:0]  tab_gain[5] = '{8'h00,   8'h28,   8'h00,   8'hFE,   8'hFF};

    initial begin
        int d0, w0, lat;
        rst          = 1'b1;
        cam_cfg_done = 1'b1;
        ae_req       = 1'b0;
        ae           = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset iic_req", 32'(iic_req), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset err", 32'(err), 0);
        chk("reset cfg_done", 32'(ae_cfg_done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Plain bursts, including gain threshold and saturation corners.
        for (int i = 0; i < 5; i++) begin
            push_burst(tab_exp[i], tab_gain[i]);
            d0 = done_cnt;
            send_req(tab_ae[i]);
            wait_busy(1'b1, 10, "burst start");
            wait_busy(1'b0, 100, "burst end");
            chk("done pulses", 32'(done_cnt - d0), 1);
            chk("err after burst", 32'(err), 0);
        end

        // Requests during a running burst: only the last one is replayed.
        push_burst(16'h07D0, 8'h00);
        push_burst(16'h09B0, 8'h00);
        d0 = done_cnt;
        send_req(8'd50);
        wait_busy(1'b1, 10, "coalesce start");
        send_req(8'd60);
        send_req(8'd61);
        send_req(8'd62);
        wait_busy(1'b0, 100, "coalesce end1");
        wait_busy(1'b1, 10, "coalesce restart");
        wait_busy(1'b0, 100, "coalesce end2");
        w0 = wr_cnt;
        repeat (10) @(negedge clk);
        chk("coalesce done pulses", 32'(done_cnt - d0), 2);
        chk("coalesce no extra writes", 32'(wr_cnt - w0), 0);

        // NACK three times on write 2 -> abort with group-hold release.
        exp_wr.push_back({16'h3001, 8'h01});
        exp_wr.push_back({16'h3021, 8'h01});
        exp_wr.push_back({16'h3020, 8'h90});
        exp_wr.push_back({16'h3020, 8'h90});
        exp_wr.push_back({16'h3020, 8'h90});
        exp_wr.push_back({16'h3001, 8'h00});
        err_addr = 16'h3020;
        err_left = 3;
        d0 = done_cnt;
        send_req(8'd10);
        wait_busy(1'b1, 10, "nack start");
        wait_busy(1'b0, 200, "nack end");
        chk("nack err flag", 32'(err), 1);
        chk("nack no done pulse", 32'(done_cnt - d0), 0);
        push_burst(16'h0000, 8'h00);
        send_req(8'd0);
        wait_busy(1'b1, 10, "clear start");
        chk("err cleared on start", 32'(err), 0);
        wait_busy(1'b0, 100, "clear end");

        // Gating: a request while config is not done waits for it.
        cam_cfg_done = 1'b0;
        w0 = wr_cnt;
        send_req(8'd30);
        repeat (10) @(negedge clk);
        chk("gated no write", 32'(wr_cnt - w0), 0);
        chk("gated not busy", 32'(busy), 0);
        push_burst(16'h04B0, 8'h00);
        cam_cfg_done = 1'b1;
        lat = 0;
        while (!iic_req && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        // Edge 1: IDLE->CALC, edge 2: CALC->ISSUE, edge 3: request rises.
        chk("gated start latency", 32'(lat), 3);
        wait_busy(1'b0, 100, "gated end");

        // No IIC response at all: three timeouts on write 0, no release.
        exp_wr.push_back({16'h3001, 8'h01});
        exp_wr.push_back({16'h3001, 8'h01});
        exp_wr.push_back({16'h3001, 8'h01});
        no_resp = 1'b1;
        d0 = done_cnt;
        send_req(8'd5);
        wait_busy(1'b1, 10, "timeout start");
        wait_busy(1'b0, 200, "timeout end");
        chk("timeout err flag", 32'(err), 1);
        chk("timeout no done pulse", 32'(done_cnt - d0), 0);
        no_resp = 1'b0;
        repeat (5) @(negedge clk);

        // Reset while waiting on write 3.
        exp_wr.push_back({16'h3001, 8'h01});
        exp_wr.push_back({16'h3021, 8'h0F});
        exp_wr.push_back({16'h3020, 8'hA0});
        exp_wr.push_back({16'h3014, 8'h28});
        send_req(8'd120);
        lat = 0;
        while (!(iic_req && iic_addr == 16'h3014) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("reached write 3", 32'(iic_addr), 32'h3014);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst iic_req", 32'(iic_req), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst err", 32'(err), 0);
        chk("rst cfg_done", 32'(ae_cfg_done), 0);
        w0 = wr_cnt;
        repeat (20) @(negedge clk);
        chk("rst no further writes", 32'(wr_cnt - w0), 0);

        chk("scoreboard drained", 32'(exp_wr.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
